// File: rtl/pipe_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipe_queue_if
// Purpose  : Handshake and status bundle between a producer/consumer
//            environment (master) and the pipe_queue storage (slave).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface pipe_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int c_cw = $clog2(DEPTH + 1);

  logic             all_ready;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [c_cw-1:0]  count;
  logic [31:0]      drop_cnt;

  // Environment side: offers data, consumes head, controls advance/flush
  modport master (
    output all_ready, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, drop_cnt
  );

  // Queue side
  modport slave (
    input  all_ready, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipe_queue
// Purpose  : Circular-buffer FIFO with global advance enable, flush with a
//            saturating discard counter, and optional accept-when-full-on-pop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pipe_queue #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter bit FULL_POP = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    reset,
  pipe_queue_if.slave  bus
);
  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_cw-1:0]  r_count;
  logic [31:0]      r_drop;

  logic             w_not_full;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [32:0]      w_drop_sum;

  assign w_not_full  = (r_count < c_full);
  assign w_out_valid = (r_count != '0);

  // FULL_POP lets a full queue accept when the consumer is taking the head
  generate
    if (FULL_POP) begin : g_full_pop
      assign w_in_ready = w_not_full | bus.out_ready;
    end else begin : g_no_full_pop
      assign w_in_ready = w_not_full;
    end
  endgenerate

  // Flush suppresses any push/pop in the same advance cycle
  assign w_flush = bus.flush & bus.all_ready;
  assign w_push  = bus.in_valid & w_in_ready & bus.all_ready & ~bus.flush;
  assign w_pop   = w_out_valid & bus.out_ready & bus.all_ready & ~bus.flush;

  assign w_drop_sum = {1'b0, r_drop} + 33'(r_count);

  // Pointers, occupancy and discard counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; stale contents are hidden by the empty mask on out_data
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem[r_rptr] : '0;
  assign bus.count     = r_count;
  assign bus.drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pipe_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pipe_queue
// Purpose  : Self-checking bench driving a FULL_POP=0 and a FULL_POP=1 queue
//            with identical directed stimulus, compared against a queue model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pipe_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic all_ready = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic check_en = 1'b0;

  int checks = 0;
  int errors = 0;

  pipe_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  pipe_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.all_ready = all_ready;
  assign bus0.flush     = flush;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.all_ready = all_ready;
  assign bus1.flush     = flush;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  pipe_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FULL_POP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  pipe_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FULL_POP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] d_out_data [2];
  logic             d_out_valid[2];
  logic             d_in_ready [2];
  logic [2:0]       d_count    [2];
  logic [31:0]      d_drop     [2];

  assign d_out_data[0]  = bus0.out_data;
  assign d_out_data[1]  = bus1.out_data;
  assign d_out_valid[0] = bus0.out_valid;
  assign d_out_valid[1] = bus1.out_valid;
  assign d_in_ready[0]  = bus0.in_ready;
  assign d_in_ready[1]  = bus1.in_ready;
  assign d_count[0]     = bus0.count;
  assign d_count[1]     = bus1.count;
  assign d_drop[0]      = bus0.drop_cnt;
  assign d_drop[1]      = bus1.drop_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is FULL_POP=0, index 1 is FULL_POP=1
  logic [WIDTH-1:0] mq[2][$];
  longint unsigned  md[2];
  bit m_rdy, m_push, m_pop;

  // Model advances on each rising edge from the inputs held across that edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k].delete();
        md[k] = 0;
      end else if (all_ready) begin
        if (flush) begin
          md[k] = md[k] + longint'(mq[k].size());
          if (md[k] > 64'hFFFF_FFFF) md[k] = 64'hFFFF_FFFF;
          mq[k].delete();
        end else begin
          m_rdy  = (mq[k].size() < DEPTH) || (k == 1 && out_ready);
          m_push = in_valid && m_rdy;
          m_pop  = (mq[k].size() != 0) && out_ready;
          if (m_pop)  void'(mq[k].pop_front());
          if (m_push) mq[k].push_back(in_data);
        end
      end
    end
  end

  // Every-cycle compare of both queues against the model
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m_count%0d", k), 64'(d_count[k]), 64'(mq[k].size()));
        chk($sformatf("m_valid%0d", k), 64'(d_out_valid[k]), 64'(mq[k].size() != 0));
        chk($sformatf("m_data%0d", k), d_out_data[k],
            (mq[k].size() != 0) ? mq[k][0] : 64'h0);
        chk($sformatf("m_ready%0d", k), 64'(d_in_ready[k]),
            64'((mq[k].size() < DEPTH) || (k == 1 && out_ready)));
        chk($sformatf("m_drop%0d", k), 64'(d_drop[k]), md[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_count", 64'(bus0.count), 64'd0);
    chk("rst_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_data", bus0.out_data, 64'd0);
    chk("rst_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_drop", 64'(bus0.drop_cnt), 64'd0);

    // Fill then drain in order
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'(17 * (i + 1));
      cyc();
      if (i == 0) begin
        chk("lat_count", 64'(bus0.count), 64'd1);
        chk("lat_data", bus0.out_data, 64'h11);
      end
    end
    in_valid = 1'b0;
    chk("fill_count", 64'(bus0.count), 64'd4);
    chk("fill_ready0", 64'(bus0.in_ready), 64'd0);
    chk("fill_ready1", 64'(bus1.in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", bus0.out_data, 64'(17 * (i + 1)));
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_data_empty", bus0.out_data, 64'd0);
    chk("drain_count", 64'(bus0.count), 64'd0);

    // Interleaved push/pop across pointer wrap
    push1(64'hA0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      in_data = 64'(32'hA0 + i);
      cyc();
      chk("wrap_count", 64'(bus0.count), 64'd1);
      chk("wrap_data", bus0.out_data, 64'(32'hA0 + i));
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("wrap_end_count", 64'(bus0.count), 64'd0);

    // Flush of 3 entries with a simultaneous offer
    push1(64'h1);
    push1(64'h2);
    push1(64'h3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hFF;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(bus0.count), 64'd0);
    chk("flush_valid", 64'(bus0.out_valid), 64'd0);
    chk("flush_drop0", 64'(bus0.drop_cnt), 64'd3);
    chk("flush_drop1", 64'(bus1.drop_cnt), 64'd3);
    push1(64'h55);
    chk("post_flush_data", bus0.out_data, 64'h55);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Everything frozen while all_ready is low
    push1(64'h61);
    push1(64'h62);
    all_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    out_ready = 1'b1;
    cyc();
    all_ready = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("hold_count", 64'(bus0.count), 64'd2);
    chk("hold_drop", 64'(bus0.drop_cnt), 64'd3);
    chk("hold_data", bus0.out_data, 64'h61);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush2_drop", 64'(bus0.drop_cnt), 64'd5);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) push1(64'(32'h81 + i));
    in_valid  = 1'b1;
    in_data   = 64'h85;
    out_ready = 1'b1;
    #1;
    chk("fp_ready1", 64'(bus1.in_ready), 64'd1);
    chk("fp_ready0", 64'(bus0.in_ready), 64'd0);
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fp_count1", 64'(bus1.count), 64'd4);
    chk("fp_count0", 64'(bus0.count), 64'd3);
    chk("fp_head1", bus1.out_data, 64'h82);
    chk("fp_head0", bus0.out_data, 64'h82);

    // Reset overrides flush on full queues
    push1(64'h86);
    chk("full_count0", 64'(bus0.count), 64'd4);
    chk("full_count1", 64'(bus1.count), 64'd4);
    reset = 1'b1;
    flush = 1'b1;
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    chk("rstf_count0", 64'(bus0.count), 64'd0);
    chk("rstf_count1", 64'(bus1.count), 64'd0);
    chk("rstf_drop", 64'(bus0.drop_cnt), 64'd0);
    chk("rstf_ready", 64'(bus0.in_ready), 64'd1);

    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_queue.md
PIPE_QUEUE -- requirements
Module: pipe_queue

Interface
REQ-001 Parameter WIDTH, default 64, payload bit width per entry (>=1).
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 Parameter FULL_POP, default 0; 1 = push accepted when full if a pop occurs the same cycle.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 all_ready  input  1  global advance enable; no state change except reset when 0.
REQ-007 flush  input  1  discard all stored entries.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  queue can accept a push this cycle.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_data  output  WIDTH  head payload; all-zero when empty (bubble encoding).
REQ-013 out_ready  input  1  downstream consumes head this cycle.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 drop_cnt  output  32  saturating total of entries discarded by flushes.

Function
REQ-016 push = in_valid & in_ready & all_ready & !flush; pop = out_valid & out_ready & all_ready & !flush.
REQ-017 out_valid SHALL equal (count != 0); combinational from state only.
REQ-018 FULL_POP=0: in_ready = (count < DEPTH), no combinational dependence on out_ready.
REQ-019 FULL_POP=1: in_ready = (count < DEPTH) | out_ready.
REQ-020 Storage SHALL be a circular buffer; write pointer advances on push, read pointer on pop, both modulo DEPTH with wrap from DEPTH-1 to 0.
REQ-021 count next = count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-022 Latency: entry pushed in cycle N is visible on out_data/out_valid in cycle N+1 at the earliest; no same-cycle bypass.
REQ-023 Order SHALL be strict FIFO; payload returned bit-exact.
REQ-024 out_data SHALL be the entry at the read pointer when count != 0, else all zeros.
REQ-025 Flush with all_ready=1: next cycle count=0, pointers=0, out_valid=0; push and pop in that cycle are suppressed.
REQ-026 Flush with all_ready=0: ignored; contents unchanged.
REQ-027 On an effective flush drop_cnt += count (pre-flush value), saturating at 32'hFFFF_FFFF.
REQ-028 Push while full with no pop (FULL_POP=1, out_ready=0) SHALL not occur since in_ready=0; pop while empty SHALL not occur since out_valid=0.
REQ-029 all_ready=0: pointers, count, storage, drop_cnt hold; outputs reflect held state.

Reset
REQ-030 reset=1 at a clock edge: count=0, both pointers=0, drop_cnt=0, out_valid=0, out_data=0, in_ready=1 next cycle.
REQ-031 Reset SHALL override flush, push, pop and all_ready in the same cycle, including mid-stream with a full queue.
REQ-032 Storage contents need not be cleared; out_data masking (REQ-024) hides stale data.

Verification
REQ-033 DEPTH=4, all_ready=1: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 4, in_ready=0; then out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order, then out_data=0, count=0.
REQ-034 Wrap: 6 pushes interleaved with 6 pops, one of each per cycle after the first push -> count steady at 1, every payload returned in order across pointer wrap.
REQ-035 Queue holding 3 entries, flush=1 with all_ready=1 -> next cycle count=0, out_valid=0, drop_cnt=3; a simultaneous in_valid=1 entry is not stored.
REQ-036 Queue holding 2 entries, flush=1, in_valid=1, out_ready=1, all_ready=0 -> no change: count=2, drop_cnt=0, same head.
REQ-037 FULL_POP=1, full queue, in_valid=1, out_ready=1 -> in_ready=1, head popped, new entry at tail, count stays 4; FULL_POP=0 same stimulus -> in_ready=0, count 3.
REQ-038 Full queue, reset=1 with flush=1 -> next cycle count=0, drop_cnt=0, in_ready=1.
